fetch_stage: RTL and testbench

- Instruction-fetch front end of the pipelined RV32 core. Sits directly upstream of decode.
- Owns the architectural PC and issues requests to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions in a 2-entry queue and hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush everything in flight.

---
 rtl/fetch_stage_if.sv | 45 ++++
 rtl/fetch_stage.sv | 88 ++++++++
 tb/tb_fetch_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Brief    : Instruction-memory, redirect and decode handshake bundle of fetch.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output id_valid,
        input  id_ready,
        output id_instr,
        output id_pc,
        output id_pc4
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  id_valid,
        output id_ready,
        input  id_instr,
        input  id_pc,
        input  id_pc4
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : RV32 fetch front end: PC, 1-cycle imem requests, 2-entry queue.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire            clk,
    input  wire            reset,
    fetch_stage_if.master  bus
);
    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic [31:0] r_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;
    logic [31:0] r_q_instr [2];
    logic [31:0] r_q_pc    [2];
    logic [1:0]  r_count;
    logic        r_head;
    logic        r_tail;

    logic        w_valid;
    logic        w_pop;
    logic        w_issue;
    logic        w_push;
    logic [2:0]  w_credit;

    // Credits count both queued words and the word still in flight, so an
    // issued fetch always has a free slot when it returns.
    always_comb begin
        w_valid  = (r_count != 2'd0);
        w_pop    = w_valid & bus.id_ready;
        w_credit = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_issue  = reset & ~bus.redirect_valid & (w_credit < 3'd2);
        w_push   = reset & ~bus.redirect_valid & r_inflight;
    end

    assign bus.imem_req  = w_issue;
    assign bus.imem_addr = r_pc;
    assign bus.id_valid  = w_valid;
    assign bus.id_instr  = w_valid ? r_q_instr[r_head]          : c_nop;
    assign bus.id_pc     = w_valid ? r_q_pc[r_head]             : 32'h0;
    assign bus.id_pc4    = w_valid ? (r_q_pc[r_head] + 32'd4)   : 32'h0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0;
            r_count       <= 2'd0;
            r_head        <= 1'b0;
            r_tail        <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_pc          <= bus.redirect_pc & ~32'd3;
            r_inflight    <= 1'b0;
            r_count       <= 2'd0;
            r_head        <= 1'b0;
            r_tail        <= 1'b0;
        end else begin
            if (w_issue) begin
                r_pc          <= r_pc + 32'd4;
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_pc;
            end else begin
                r_inflight    <= 1'b0;
            end
            if (w_push) begin
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Queue payload needs no reset; id_* outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_tail] <= bus.imem_rdata;
            r_q_pc[r_tail]    <= r_inflight_pc;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage (vector table, corner cases, random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic clk = 1'b0;
    logic reset;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hAAAA_0000 | a;
    endfunction

    // Instruction memory: answers a request one cycle later, garbage otherwise.
    always @(posedge clk) begin
        if (bus.imem_req)
            bus.imem_rdata <= mem_word(bus.imem_addr);
        else
            bus.imem_rdata <= $urandom;
    end

    // Reference model: expected delivery order as plain queues of PCs.
    logic [31:0] m_q[$];
    logic [31:0] m_pend[$];
    logic [31:0] m_pc;

    int n_pass  = 0;
    int n_total = 0;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_pc, s_pc4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input logic rs, input logic rdy, input logic rv, input logic [31:0] rpc);
        logic        e_req, e_valid, pop;
        logic [31:0] e_pc;
        int          occ;
        @(negedge clk);
        reset              = rs;
        bus.id_ready       = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_valid = bus.id_valid;
        s_instr = bus.id_instr;
        s_pc    = bus.id_pc;
        s_pc4   = bus.id_pc4;

        e_valid = (m_q.size() != 0);
        e_pc    = 32'h0;
        if (e_valid) e_pc = m_q[0];
        pop   = e_valid & rdy;
        occ   = m_q.size() + m_pend.size() - (pop ? 1 : 0);
        e_req = rs & ~rv & (occ < 2);

        chk("imem_req", 32'(s_req), 32'(e_req));
        if (e_req) chk("imem_addr", s_addr, m_pc);
        chk("id_valid", 32'(s_valid), 32'(e_valid));
        chk("id_pc", s_pc, e_pc);
        chk("id_pc4", s_pc4, e_valid ? e_pc + 32'd4 : 32'h0);
        chk("id_instr", s_instr, e_valid ? mem_word(e_pc) : 32'h0000_0013);
        chk("count_le2", 32'(dut.r_count <= 2'd2), 32'd1);

        @(posedge clk);
        if (!rs) begin
            m_q.delete(); m_pend.delete(); m_pc = RST_PC;
        end else if (rv) begin
            m_q.delete(); m_pend.delete(); m_pc = rpc & ~32'd3;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_pend.size() != 0) m_q.push_back(m_pend.pop_front());
            if (e_req) begin
                m_pend.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    typedef struct packed {
        logic        rs;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl [16];

    initial begin
        reset              = 1'b0;
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        m_q.delete(); m_pend.delete(); m_pc = RST_PC;

        //            rs    rdy   rv    rpc           req   addr          valid pc
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h100,    1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h104,    1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h108,    1'b1, 32'h100};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h10C,    1'b1, 32'h104};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b1, 32'h108};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b1, 32'h108};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b1, 32'h108};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h110,    1'b1, 32'h108};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h114,    1'b1, 32'h10C};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h118,    1'b1, 32'h110};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h2002,   1'b0, 32'h0,      1'b1, 32'h114};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h2000,   1'b0, 32'h0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h2004,   1'b0, 32'h0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h2008,   1'b1, 32'h2000};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h200C,   1'b1, 32'h2004};

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rs, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
            chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].req));
            if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].pc);
        end

        // Back-to-back redirects while a pop and a return are both pending.
        step(1'b1, 1'b1, 1'b1, 32'h0000_0300);
        chk("b2b_req0", 32'(s_req), 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0400);
        chk("b2b_req1", 32'(s_req), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("b2b_fetch_addr", s_addr, 32'h400);
        chk("b2b_empty1", 32'(s_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("b2b_empty2", 32'(s_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("b2b_first_pc", s_pc, 32'h400);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("b2b_second_pc", s_pc, 32'h404);

        // PC wrap through the top of the address space.
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_pc0", s_pc, 32'hFFFF_FFF8);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_pc1", s_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", s_pc4, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_pc2", s_pc, 32'h0);

        // Reset in the middle of a stall with the queue populated.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst_mid_req", 32'(s_req), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rst_mid_valid", 32'(s_valid), 32'd0);
        chk("rst_mid_instr", s_instr, 32'h0000_0013);
        chk("rst_mid_addr", s_addr, RST_PC);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rst_mid_pc", s_pc, RST_PC);

        // Randomised traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            logic        rs, rdy, rv;
            logic [31:0] rpc;
            rs  = ($urandom_range(0, 59) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 24) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            step(rs, rdy, rv, rpc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
